// File: rtl/execute_if.sv
// Decode-to-execute bundle and execute-stage results for the LC-3 pipeline.
// The slave side is the execute stage; the master side is its environment.
interface execute_if;
  logic        enable_execute;
  logic [15:0] IR;
  logic [15:0] npc_in;
  logic [5:0]  E_control;
  logic        Mem_Control_in;
  logic [1:0]  W_Control_in;
  logic [15:0] VSR1;
  logic [15:0] VSR2;
  logic        bypass_alu_1;
  logic        bypass_alu_2;
  logic        bypass_mem_1;
  logic        bypass_mem_2;
  logic [15:0] Mem_Bypass_Val;
  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic [15:0] aluout;
  logic [15:0] pcout;
  logic [2:0]  dr;
  logic [15:0] IR_Exec;
  logic [2:0]  NZP;
  logic [15:0] M_Data;
  logic        Mem_Control_out;
  logic [1:0]  W_Control_out;

  modport slave (
    input  enable_execute, IR, npc_in,
    input  E_control, Mem_Control_in,
    input  W_Control_in, VSR1, VSR2,
    input  bypass_alu_1, bypass_alu_2,
    input  bypass_mem_1, bypass_mem_2,
    input  Mem_Bypass_Val,
    output sr1, sr2, aluout, pcout, dr,
    output IR_Exec, NZP, M_Data,
    output Mem_Control_out, W_Control_out
  );

  modport master (
    output enable_execute, IR, npc_in,
    output E_control, Mem_Control_in,
    output W_Control_in, VSR1, VSR2,
    output bypass_alu_1, bypass_alu_2,
    output bypass_mem_1, bypass_mem_2,
    output Mem_Bypass_Val,
    input  sr1, sr2, aluout, pcout, dr,
    input  IR_Exec, NZP, M_Data,
    input  Mem_Control_out, W_Control_out
  );
endinterface

// File: rtl/execute.sv
// LC-3 execute stage: ALU, effective address, forwarding,
// and the registered bundle handed to memory/writeback.
module execute (
  input logic        clock,
  input logic        reset,
  execute_if.slave   bus
);
  logic [3:0] op;
  logic is_add, is_and, is_not, is_br, is_jmp;
  logic is_ld, is_ldr, is_ldi, is_lea;
  logic is_st, is_str, is_sti;

  assign op     = bus.IR[15:12];
  assign is_add = (op == 4'b0001);
  assign is_and = (op == 4'b0101);
  assign is_not = (op == 4'b1001);
  assign is_br  = (op == 4'b0000);
  assign is_jmp = (op == 4'b1100);
  assign is_ld  = (op == 4'b0010);
  assign is_ldr = (op == 4'b0110);
  assign is_ldi = (op == 4'b1010);
  assign is_lea = (op == 4'b1110);
  assign is_st  = (op == 4'b0011);
  assign is_str = (op == 4'b0111);
  assign is_sti = (op == 4'b1011);

  logic [1:0] alu_ctl;
  logic [1:0] pcsel1;
  logic       pcsel2;
  logic       op2sel;

  assign alu_ctl = bus.E_control[5:4];
  assign pcsel1  = bus.E_control[3:2];
  assign pcsel2  = bus.E_control[1];
  assign op2sel  = bus.E_control[0];

  logic [15:0] aluout_q, aluout_d;
  logic [15:0] pcout_q, pcout_d;
  logic [2:0]  dr_q, dr_d;
  logic [15:0] ir_q;
  logic [2:0]  nzp_q, nzp_d;
  logic [15:0] mdata_q;
  logic        memc_q;
  logic [1:0]  wc_q;

  logic [15:0] val1, val2, alu_b, alu_r;
  logic [15:0] offset, base;

  assign bus.sr1 =
    (is_add | is_and | is_not |
     is_ldr | is_str | is_jmp) ?
    bus.IR[8:6] : 3'd0;

  always_comb begin
    bus.sr2 = 3'd0;
    unique case (1'b1)
      is_add, is_and, is_not:
        bus.sr2 = bus.IR[2:0];
      is_st, is_str, is_sti:
        bus.sr2 = bus.IR[11:9];
      default: bus.sr2 = 3'd0;
    endcase
  end

  // The ALU forward carries the previous instruction's result,
  // so it must win over the older memory-stage value.
  assign val1 =
    bus.bypass_alu_1 ? aluout_q :
    bus.bypass_mem_1 ? bus.Mem_Bypass_Val :
    bus.VSR1;
  assign val2 =
    bus.bypass_alu_2 ? aluout_q :
    bus.bypass_mem_2 ? bus.Mem_Bypass_Val :
    bus.VSR2;

  assign alu_b = op2sel ? val2 :
    {{11{bus.IR[4]}}, bus.IR[4:0]};

  always_comb begin
    alu_r = 16'd0;
    case (alu_ctl)
      2'b00:   alu_r = val1 + alu_b;
      2'b01:   alu_r = val1 & alu_b;
      2'b10:   alu_r = ~val1;
      default: alu_r = val1;
    endcase
  end

  always_comb begin
    offset = 16'd0;
    case (pcsel1)
      2'b00: offset =
        {{5{bus.IR[10]}}, bus.IR[10:0]};
      2'b01: offset =
        {{7{bus.IR[8]}}, bus.IR[8:0]};
      2'b10: offset =
        {{10{bus.IR[5]}}, bus.IR[5:0]};
      default: offset = 16'd0;
    endcase
  end

  assign base    = pcsel2 ? bus.npc_in : val1;
  assign pcout_d = base + offset;
  assign aluout_d = is_lea ? pcout_d : alu_r;

  always_comb begin
    dr_d  = 3'd0;
    nzp_d = 3'd0;
    unique case (1'b1)
      is_add, is_and, is_not,
      is_ld, is_ldr, is_ldi, is_lea:
        dr_d = bus.IR[11:9];
      is_br:   nzp_d = bus.IR[11:9];
      is_jmp:  nzp_d = 3'b111;
      default: begin
        dr_d  = 3'd0;
        nzp_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      aluout_q <= 16'd0;
      pcout_q  <= 16'd0;
      dr_q     <= 3'd0;
      ir_q     <= 16'd0;
      nzp_q    <= 3'd0;
      mdata_q  <= 16'd0;
      memc_q   <= 1'b0;
      wc_q     <= 2'd0;
    end else if (bus.enable_execute) begin
      aluout_q <= aluout_d;
      pcout_q  <= pcout_d;
      dr_q     <= dr_d;
      ir_q     <= bus.IR;
      nzp_q    <= nzp_d;
      mdata_q  <= val2;
      memc_q   <= bus.Mem_Control_in;
      wc_q     <= bus.W_Control_in;
    end
  end

  assign bus.aluout          = aluout_q;
  assign bus.pcout           = pcout_q;
  assign bus.dr              = dr_q;
  assign bus.IR_Exec         = ir_q;
  assign bus.NZP             = nzp_q;
  assign bus.M_Data          = mdata_q;
  assign bus.Mem_Control_out = memc_q;
  assign bus.W_Control_out   = wc_q;
endmodule

// File: tb/tb_execute.sv
// Directed-vector bench for the LC-3 execute stage.
// Expected values are hand-computed from the instruction encodings.
module tb_execute;
  logic clock;
  logic reset;
  int   n_chk;
  int   n_fail;

  execute_if bus ();

  execute dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(
    input logic [15:0] ir,
    input logic [15:0] npc,
    input logic [5:0]  ec,
    input logic [15:0] v1,
    input logic [15:0] v2
  );
    bus.IR        = ir;
    bus.npc_in    = npc;
    bus.E_control = ec;
    bus.VSR1      = v1;
    bus.VSR2      = v2;
  endtask

  task automatic byp(
    input logic a1, input logic a2,
    input logic m1, input logic m2,
    input logic [15:0] mv
  );
    bus.bypass_alu_1   = a1;
    bus.bypass_alu_2   = a2;
    bus.bypass_mem_1   = m1;
    bus.bypass_mem_2   = m2;
    bus.Mem_Bypass_Val = mv;
  endtask

  initial begin
    logic [15:0] hir [3];
    hir[0] = 16'h1283;
    hir[1] = 16'h5262;
    hir[2] = 16'h927F;
    n_chk  = 0;
    n_fail = 0;

    // reset with live nonzero inputs
    reset = 1'b0;
    bus.enable_execute = 1'b1;
    bus.Mem_Control_in = 1'b1;
    bus.W_Control_in   = 2'b11;
    drive(16'h1283, 16'h3000, 6'b000001,
          16'h0005, 16'hFFFF);
    byp(1, 1, 1, 1, 16'h1234);
    step();
    check("rst_alu", bus.aluout, 16'h0);
    check("rst_pc", bus.pcout, 16'h0);
    check("rst_dr", 16'(bus.dr), 16'h0);
    check("rst_ir", bus.IR_Exec, 16'h0);
    check("rst_nzp", 16'(bus.NZP), 16'h0);
    check("rst_md", bus.M_Data, 16'h0);
    check("rst_mc",
          16'(bus.Mem_Control_out), 16'h0);
    check("rst_wc",
          16'(bus.W_Control_out), 16'h0);

    // ADD register form
    reset = 1'b1;
    byp(0, 0, 0, 0, 16'h0000);
    bus.Mem_Control_in = 1'b1;
    bus.W_Control_in   = 2'b10;
    drive(16'h1283, 16'h3000, 6'b000001,
          16'h0005, 16'hFFFF);
    #1;
    check("add_sr1", 16'(bus.sr1), 16'd2);
    check("add_sr2", 16'(bus.sr2), 16'd3);
    step();
    check("add_alu", bus.aluout, 16'h0004);
    check("add_dr", 16'(bus.dr), 16'd1);
    check("add_nzp", 16'(bus.NZP), 16'd0);
    check("add_pc", bus.pcout, 16'h0288);
    check("add_ir", bus.IR_Exec, 16'h1283);
    check("add_md", bus.M_Data, 16'hFFFF);
    check("add_mc",
          16'(bus.Mem_Control_out), 16'd1);
    check("add_wc",
          16'(bus.W_Control_out), 16'd2);

    // AND immediate, NOT
    bus.Mem_Control_in = 1'b0;
    bus.W_Control_in   = 2'b01;
    drive(16'h5262, 16'h3000, 6'b010000,
          16'h0007, 16'hAAAA);
    step();
    check("and_alu", bus.aluout, 16'h0002);
    check("and_dr", 16'(bus.dr), 16'd1);
    drive(16'h927F, 16'h3000, 6'b100000,
          16'h00FF, 16'h0000);
    step();
    check("not_alu", bus.aluout, 16'hFF00);
    check("not_dr", 16'(bus.dr), 16'd1);

    // BR, LEA (negative offset), JMP
    drive(16'h0E05, 16'h3001, 6'b000110,
          16'h1111, 16'h2222);
    #1;
    check("br_sr1", 16'(bus.sr1), 16'd0);
    check("br_sr2", 16'(bus.sr2), 16'd0);
    step();
    check("br_pc", bus.pcout, 16'h3006);
    check("br_nzp", 16'(bus.NZP), 16'd7);
    check("br_dr", 16'(bus.dr), 16'd0);
    drive(16'hE1FF, 16'h3001, 6'b000110,
          16'h1111, 16'h2222);
    step();
    check("lea_pc", bus.pcout, 16'h3000);
    check("lea_alu", bus.aluout, 16'h3000);
    check("lea_dr", 16'(bus.dr), 16'd0);
    check("lea_nzp", 16'(bus.NZP), 16'd0);
    drive(16'hC1C0, 16'h3001, 6'b111100,
          16'h4000, 16'h0000);
    #1;
    check("jmp_sr1", 16'(bus.sr1), 16'd7);
    step();
    check("jmp_pc", bus.pcout, 16'h4000);
    check("jmp_nzp", 16'(bus.NZP), 16'd7);
    check("jmp_dr", 16'(bus.dr), 16'd0);

    // forwarding chain
    drive(16'h1283, 16'h3000, 6'b000001,
          16'h0005, 16'hFFFF);
    step();
    check("fw0_alu", bus.aluout, 16'h0004);
    byp(1, 0, 0, 0, 16'h0000);
    drive(16'h1283, 16'h3000, 6'b000001,
          16'h0100, 16'h0001);
    step();
    check("fwa1_alu", bus.aluout, 16'h0005);
    byp(0, 1, 0, 1, 16'h1234);
    drive(16'h1283, 16'h3000, 6'b000001,
          16'h0010, 16'h7777);
    step();
    check("fwpri2_alu", bus.aluout, 16'h0015);
    check("fwpri2_md", bus.M_Data, 16'h0005);
    byp(0, 0, 1, 0, 16'h1234);
    drive(16'h1283, 16'h3000, 6'b000001,
          16'h0999, 16'h0002);
    step();
    check("fwm1_alu", bus.aluout, 16'h1236);
    byp(1, 0, 1, 0, 16'h1234);
    drive(16'h1283, 16'h3000, 6'b000001,
          16'h0999, 16'h0001);
    step();
    check("fwpri1_alu", bus.aluout, 16'h1237);

    // STR with memory forward on store data
    byp(0, 0, 0, 1, 16'h1234);
    drive(16'h7283, 16'h3000, 6'b001000,
          16'h2000, 16'hDEAD);
    #1;
    check("str_sr1", 16'(bus.sr1), 16'd2);
    check("str_sr2", 16'(bus.sr2), 16'd1);
    step();
    check("str_md", bus.M_Data, 16'h1234);
    check("str_pc", bus.pcout, 16'h2003);
    check("str_dr", 16'(bus.dr), 16'd0);
    check("str_nzp", 16'(bus.NZP), 16'd0);

    // ST source index only
    byp(0, 0, 0, 0, 16'h0000);
    drive(16'h3A05, 16'h3000, 6'b000100,
          16'h0000, 16'h0000);
    #1;
    check("st_sr1", 16'(bus.sr1), 16'd0);
    check("st_sr2", 16'(bus.sr2), 16'd5);

    // hold for three cycles
    bus.enable_execute = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(hir[i], 16'h5000 + 16'(i),
            6'b000001, 16'h0F0F, 16'hF0F0);
      bus.Mem_Control_in = 1'b1;
      #1;
      check("hold_sr1", 16'(bus.sr1),
            {13'd0, hir[i][8:6]});
      check("hold_sr2", 16'(bus.sr2),
            {13'd0, hir[i][2:0]});
      step();
      check("hold_ir", bus.IR_Exec, 16'h7283);
      check("hold_pc", bus.pcout, 16'h2003);
      check("hold_alu", bus.aluout, 16'h2003);
      check("hold_md", bus.M_Data, 16'h1234);
      check("hold_mc",
            16'(bus.Mem_Control_out), 16'd0);
    end

    // unlisted opcode 1101
    bus.enable_execute = 1'b1;
    drive(16'hD283, 16'h3000, 6'b000001,
          16'h0005, 16'h0003);
    #1;
    check("unl_sr1", 16'(bus.sr1), 16'd0);
    check("unl_sr2", 16'(bus.sr2), 16'd0);
    step();
    check("unl_alu", bus.aluout, 16'h0008);
    check("unl_dr", 16'(bus.dr), 16'd0);
    check("unl_nzp", 16'(bus.NZP), 16'd0);

    // reset mid-stream discards the in-flight op
    reset = 1'b0;
    drive(16'h1283, 16'h3000, 6'b000001,
          16'h0005, 16'hFFFF);
    step();
    check("rst2_alu", bus.aluout, 16'h0);
    check("rst2_ir", bus.IR_Exec, 16'h0);
    check("rst2_dr", 16'(bus.dr), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end
endmodule
